// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, WIDTH-cycle RUN phase.
// Optional macro SUB_OVF_EN adds the signed-overflow output OVF.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done,
`ifdef SUB_OVF_EN
    output logic             OVF,
`endif
    output logic [1:0]       o_dbg_state
);

    // Handshake: start is a request sampled only in IDLE (A/B captured on that
    // edge); done is a one-cycle pulse and D/Bout are valid from then until the next done.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
`ifdef SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_a        = r_a[0];
    assign w_b        = r_b[0];
    assign w_d        = w_a ^ w_b ^ r_br;
    assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    // New bit enters at the MSB; after WIDTH shifts the word is aligned.
    assign w_res_next = {w_d, r_res};
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            D       <= '0;
            Bout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            OVF     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
`ifdef SUB_OVF_EN
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        D       <= w_res_next;
                        Bout    <= w_br_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
`ifdef SUB_OVF_EN
                        OVF     <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); define SUB_OVF_EN to also check OVF.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             busy;
    logic             done;
    logic [1:0]       o_dbg_state;
`ifdef SUB_OVF_EN
    logic             OVF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .D          (D),
        .Bout       (Bout),
        .busy       (busy),
        .done       (done),
`ifdef SUB_OVF_EN
        .OVF        (OVF),
`endif
        .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: issue start for one edge, return on the negedge after that edge.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
    endtask

    // Monitor: counts cycles until done (bounded), and busy-high cycles seen.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        A = 8'hAA;
        B = 8'h11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        n_checks++; if (D !== 8'h00)  begin n_fail++; $display("FAIL reset_D got %h exp 00", D); end
        n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL reset_Bout got %b exp 0", Bout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (o_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", o_dbg_state); end
`ifdef SUB_OVF_EN
        n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_OVF got %b exp 0", OVF); end
`endif
    endtask

    task automatic test_basic();
        int cycles, busy_cycles;
        drive_start(8'h05, 8'h03);
        n_checks++; if (o_dbg_state !== S_RUN) begin n_fail++; $display("FAIL basic_state got %0d exp 1", o_dbg_state); end
        wait_done(cycles, busy_cycles);
        n_checks++; if (cycles != WIDTH) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", cycles, WIDTH); end
        n_checks++; if (busy_cycles != WIDTH) begin n_fail++; $display("FAIL basic_busy_cycles got %0d exp %0d", busy_cycles, WIDTH); end
        n_checks++; if (D !== 8'h02) begin n_fail++; $display("FAIL basic_D got %h exp 02", D); end
        n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL basic_Bout got %b exp 0", Bout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done got %b exp 0", busy); end
`ifdef SUB_OVF_EN
        n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL basic_OVF got %b exp 0", OVF); end
`endif
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        n_checks++; if (o_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL basic_back_idle got %0d exp 0", o_dbg_state); end
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va [5] = '{8'h03, 8'h00, 8'h5A, 8'hFF, 8'h80};
        logic [WIDTH-1:0] vb [5] = '{8'h05, 8'h00, 8'h5A, 8'h00, 8'h01};
        logic [WIDTH-1:0] vd [5] = '{8'hFE, 8'h00, 8'h00, 8'hFF, 8'h7F};
        logic             vbo[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int cycles, busy_cycles;
        for (int i = 0; i < 5; i++) begin
            drive_start(va[i], vb[i]);
            wait_done(cycles, busy_cycles);
            n_checks++; if (cycles != WIDTH) begin n_fail++; $display("FAIL vec%0d_latency got %0d exp %0d", i, cycles, WIDTH); end
            n_checks++; if (D !== vd[i]) begin n_fail++; $display("FAIL vec%0d_D got %h exp %h", i, D, vd[i]); end
            n_checks++; if (Bout !== vbo[i]) begin n_fail++; $display("FAIL vec%0d_Bout got %b exp %b", i, Bout, vbo[i]); end
        end
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] va [3] = '{8'h80, 8'h7F, 8'h05};
        logic [WIDTH-1:0] vb [3] = '{8'h01, 8'hFF, 8'h03};
        logic [WIDTH-1:0] vd [3] = '{8'h7F, 8'h80, 8'h02};
        logic             vo [3] = '{1'b1, 1'b1, 1'b0};
        int cycles, busy_cycles;
        for (int i = 0; i < 3; i++) begin
            drive_start(va[i], vb[i]);
            wait_done(cycles, busy_cycles);
            n_checks++; if (D !== vd[i]) begin n_fail++; $display("FAIL ovf%0d_D got %h exp %h", i, D, vd[i]); end
            n_checks++; if (OVF !== vo[i]) begin n_fail++; $display("FAIL ovf%0d_OVF got %b exp %b", i, OVF, vo[i]); end
        end
    endtask
`endif

    task automatic test_hold();
        int cycles, busy_cycles;
        drive_start(8'h07, 8'h0A);
        wait_done(cycles, busy_cycles);
        repeat (3) @(negedge clk);
        n_checks++; if (D !== 8'hFD) begin n_fail++; $display("FAIL hold_idle_D got %h exp fd", D); end
        n_checks++; if (Bout !== 1'b1) begin n_fail++; $display("FAIL hold_idle_Bout got %b exp 1", Bout); end
        drive_start(8'h10, 8'h01);
        repeat (4) @(negedge clk);
        n_checks++; if (D !== 8'hFD) begin n_fail++; $display("FAIL hold_run_D got %h exp fd", D); end
        n_checks++; if (Bout !== 1'b1) begin n_fail++; $display("FAIL hold_run_Bout got %b exp 1", Bout); end
        wait_done(cycles, busy_cycles);
        n_checks++; if (D !== 8'h0F) begin n_fail++; $display("FAIL hold_next_D got %h exp 0f", D); end
        n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL hold_next_Bout got %b exp 0", Bout); end
    endtask

    task automatic test_ignore_start();
        int pulses, cycles;
        drive_start(8'h10, 8'h01);   // now in 1st RUN cycle
        @(negedge clk);              // 2nd RUN cycle
        @(negedge clk);              // 3rd RUN cycle
        A = 8'hFF;
        B = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        cycles = 3;
        while (pulses == 0 && cycles < 20) begin
            if (done) pulses++;
            else begin @(negedge clk); cycles++; end
        end
        n_checks++; if (cycles != WIDTH) begin n_fail++; $display("FAIL ignore_latency got %0d exp %0d", cycles, WIDTH); end
        n_checks++; if (D !== 8'h0F) begin n_fail++; $display("FAIL ignore_D got %h exp 0f", D); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_reset_abort();
        int pulses, cycles, busy_cycles;
        drive_start(8'h05, 8'h09);   // 1st RUN cycle
        repeat (3) @(negedge clk);   // 4th RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_done_pulses got %0d exp 0", pulses); end
        n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL abort_D got %h exp 00", D); end
        n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL abort_Bout got %b exp 0", Bout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        drive_start(8'h09, 8'h09);
        wait_done(cycles, busy_cycles);
        n_checks++; if (cycles != WIDTH) begin n_fail++; $display("FAIL after_abort_latency got %0d exp %0d", cycles, WIDTH); end
        n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL after_abort_D got %h exp 00", D); end
        n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL after_abort_Bout got %b exp 0", Bout); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_basic();
        test_vectors();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        test_hold();
        test_ignore_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
